// File: rtl/lane_arb_pkg.sv
// -----------------------------------------------------------------------------
// lane_arb_pkg
// Shared definitions for the lane arbiter slice:
//   - laneState_t   : arbiter FSM state encoding (IDLE / DRIVE / RESP)
//   - DEFAULT_WIDTH : default lane data width
//   - id_width(n)   : width of a requester index for n requesters (min 1 bit)
// -----------------------------------------------------------------------------
package lane_arb_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } laneState_t;

  // A single requester still needs a 1-bit ID port so resp_id is never zero-width.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational cyclic priority picker. Selects the first set bit of reqVec
// at or after rrPtr, wrapping from N_REQ-1 back to 0.
//
// Ports:
//   reqVec      in  N_REQ  request vector
//   rrPtr       in  ID_W   index with highest priority (must be < N_REQ)
//   grantOneHot out N_REQ  one-hot grant, all zero when nothing requested
//   grantIdx    out ID_W   encoded grant index (0 when nothing requested)
//   any         out 1      at least one request bit is set
// -----------------------------------------------------------------------------
module rr_picker
  import lane_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] reqVec,
  input  logic [ID_W-1:0]  rrPtr,
  output logic [N_REQ-1:0] grantOneHot,
  output logic [ID_W-1:0]  grantIdx,
  output logic             any
);

  // candIdx[k] is the requester sitting k places after rrPtr; rotReq[k] is
  // its request bit, so priority is simply "lowest k wins".
  logic [ID_W-1:0]  candIdx [N_REQ];
  logic [N_REQ-1:0] rotReq;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rotate
    // One extra bit so rrPtr + gi cannot overflow before the modulo fold.
    logic [ID_W:0] sum;
    assign sum = {1'b0, rrPtr} + (ID_W+1)'(gi);
    // rrPtr < N_REQ and gi < N_REQ, so a single subtraction is a full modulo.
    assign candIdx[gi] = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                                    : ID_W'(sum);
    assign rotReq[gi]  = reqVec[candIdx[gi]];
  end

  // Scan from the farthest candidate down so the nearest one is written last.
  always_comb begin
    grantIdx = '0;
    any      = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rotReq[k]) begin
        grantIdx = candIdx[k];
        any      = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign grantOneHot[gi] = any && (grantIdx == ID_W'(gi));
  end

endmodule

// File: rtl/lane_arbiter.sv
// -----------------------------------------------------------------------------
// lane_arbiter
// Round-robin arbiter sharing one passthrough lane between N_REQ requesters.
// A request is accepted in IDLE, its word is presented on lane_in, the lane's
// combinational reply is sampled one cycle later (DRIVE), and the sampled word
// is offered on the response port (RESP) until consumed.
//
// Ports:
//   clock       in  1            clock
//   reset       in  1            synchronous, active-low reset
//   req_valid   in  N_REQ        per-requester request valid
//   req_data    in  N_REQ*WIDTH  per-requester word, slice i = requester i
//   req_ready   out N_REQ        accept strobe, one-hot or zero
//   lane_in     out WIDTH        word driven into the passthrough
//   lane_out    in  WIDTH        passthrough reply (combinational of lane_in)
//   resp_valid  out 1            response available
//   resp_ready  in  1            response consumer ready
//   resp_id     out ID_W         requester being answered
//   resp_data   out WIDTH        sampled lane_out
//   mismatch    out 1            sticky: a sampled reply differed from lane_in
//   busy        out 1            FSM not in IDLE
// -----------------------------------------------------------------------------
module lane_arbiter
  import lane_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       lane_in,
  input  logic [WIDTH-1:0]       lane_out,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   mismatch,
  output logic                   busy
);

  laneState_t       stateReg;
  laneState_t       stateNext;
  logic [ID_W-1:0]  rrPtrReg;
  logic [ID_W-1:0]  curIdReg;
  logic [ID_W-1:0]  respIdReg;
  logic [WIDTH-1:0] holdReg;
  logic [WIDTH-1:0] respDataReg;
  logic             mismatchReg;

  logic [N_REQ-1:0] grantOneHot;
  logic [ID_W-1:0]  grantIdx;
  logic             grantAny;
  logic [ID_W-1:0]  ptrAfterCur;

  // Unpack the flat request bus so the granted word can be selected by index.
  logic [WIDTH-1:0] reqWord [N_REQ];
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign reqWord[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) picker (
    .reqVec      (req_valid),
    .rrPtr       (rrPtrReg),
    .grantOneHot (grantOneHot),
    .grantIdx    (grantIdx),
    .any         (grantAny)
  );

  // The requester just served drops to lowest priority next round.
  assign ptrAfterCur = (curIdReg == ID_W'(N_REQ - 1)) ? '0 : curIdReg + ID_W'(1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      IDLE:    if (grantAny)   stateNext = DRIVE;
      DRIVE:                   stateNext = RESP;
      RESP:    if (resp_ready) stateNext = IDLE;
      default:                 stateNext = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready  = '0;
    // Gate with reset so no requester sees an accept that the reset discards.
    if ((stateReg == IDLE) && reset) begin
      req_ready = grantOneHot;
    end
    resp_valid = (stateReg == RESP);
    busy       = (stateReg != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath: held word, response capture, sticky mismatch, round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      rrPtrReg    <= '0;
      curIdReg    <= '0;
      holdReg     <= '0;
      respDataReg <= '0;
      respIdReg   <= '0;
      mismatchReg <= 1'b0;
    end else begin
      unique case (stateReg)
        IDLE: begin
          if (grantAny) begin
            holdReg  <= reqWord[grantIdx];
            curIdReg <= grantIdx;
          end
        end
        DRIVE: begin
          // lane_in has been stable since the accept edge, so lane_out has
          // had a full cycle to settle before it is captured here.
          respDataReg <= lane_out;
          respIdReg   <= curIdReg;
          if (lane_out != holdReg) begin
            mismatchReg <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            rrPtrReg <= ptrAfterCur;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The lane keeps seeing the last accepted word until the next accept.
  assign lane_in   = holdReg;
  assign resp_data = respDataReg;
  assign resp_id   = respIdReg;
  assign mismatch  = mismatchReg;

endmodule

// File: tb/tb_lane_arbiter.sv
`timescale 1ns/1ps
module tb_lane_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic           clock      = 1'b0;
  logic           reset      = 1'b0;
  logic [N-1:0]   req_valid  = '0;
  logic [N*W-1:0] req_data   = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   lane_in;
  logic [W-1:0]   lane_out;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  logic [IW-1:0]  resp_id;
  logic [W-1:0]   resp_data;
  logic           mismatch;
  logic           busy;

  logic laneFault = 1'b0;
  int   testCount = 0;
  int   failCount = 0;
  int   cyc       = 0;

  // Reference model state: who has priority next and whether a bad reply was seen.
  int   modelPtr  = 0;
  logic modelMism = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Passthrough lane: identity, or bit 0 inverted when a fault is injected.
  assign lane_out = laneFault ? (lane_in ^ W'(1)) : lane_in;

  lane_arbiter #(
    .N_REQ (N),
    .WIDTH (W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .lane_in    (lane_in),
    .lane_out   (lane_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .mismatch   (mismatch),
    .busy       (busy)
  );

  typedef struct packed {
    logic          ok;
    logic [N-1:0]  rdy;
    logic          driveValid;
    logic [N-1:0]  midReady;
    logic          respValid;
    logic [IW-1:0] respId;
    logic [W-1:0]  respData;
    logic          mism;
    logic          lateValid;
    logic [IW-1:0] lateId;
    logic [W-1:0]  lateData;
    logic          busyAfter;
    int            lat;
  } obs_t;

  // ---------------------------------------------------------------------------
  // Model: cyclic search from the priority pointer, lane as identity or fault.
  // ---------------------------------------------------------------------------
  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int idx = (modelPtr + k) % N;
      if (((v >> idx) & N'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] model_lane(input logic [W-1:0] d, input logic f);
    return f ? (d ^ W'(1)) : d;
  endfunction

  function automatic logic [W-1:0] word_of(input int i);
    return req_data[i*W +: W];
  endfunction

  task automatic set_word(input int i, input logic [W-1:0] d);
    req_data[i*W +: W] = d;
  endtask

  // Runs one transaction from an IDLE negedge and records what the DUT shows;
  // all judging is left to the calling test.
  task automatic txn(input logic [N-1:0] v, input int delay, output obs_t o);
    int startCyc;
    o = '0;
    req_valid  = v;
    resp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req_ready !== '0) begin
        o.ok  = 1'b1;
        o.rdy = req_ready;
        break;
      end
      @(negedge clock);
    end
    if (o.ok !== 1'b1) begin
      req_valid = '0;
      return;
    end
    startCyc = cyc;
    @(negedge clock);
    o.driveValid = resp_valid;
    o.midReady   = req_ready;
    @(negedge clock);
    o.respValid = resp_valid;
    o.respId    = resp_id;
    o.respData  = resp_data;
    o.mism      = mismatch;
    o.lat       = cyc - startCyc;
    o.midReady  = o.midReady | req_ready;
    for (int d = 0; d < delay; d++) begin
      @(negedge clock);
      o.midReady = o.midReady | req_ready;
    end
    o.lateValid = resp_valid;
    o.lateId    = resp_id;
    o.lateData  = resp_data;
    resp_ready  = 1'b1;
    @(negedge clock);
    o.busyAfter = busy;
    resp_ready  = 1'b0;
    req_valid   = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '1;
    for (int i = 0; i < N; i++) set_word(i, $urandom);
    repeat (3) @(negedge clock);
    #1;
    testCount++; if (req_ready !== '0) begin failCount++; $display("FAIL reset_req_ready: got %b, expected 0", req_ready); end
    testCount++; if (resp_valid !== 1'b0) begin failCount++; $display("FAIL reset_resp_valid: got %b, expected 0", resp_valid); end
    testCount++; if (busy !== 1'b0) begin failCount++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    testCount++; if (mismatch !== 1'b0) begin failCount++; $display("FAIL reset_mismatch: got %b, expected 0", mismatch); end
    testCount++; if (lane_in !== '0) begin failCount++; $display("FAIL reset_lane_in: got %h, expected 0", lane_in); end
    testCount++; if (resp_data !== '0 || resp_id !== '0) begin failCount++; $display("FAIL reset_resp: got data %h id %0d, expected 0/0", resp_data, resp_id); end
    req_valid = '0;
    @(negedge clock);
    reset = 1'b1;
    // No requests: the arbiter must sit in IDLE with outputs unchanged.
    repeat (5) @(negedge clock);
    testCount++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin failCount++; $display("FAIL idle_state: got busy %b valid %b, expected 0/0", busy, resp_valid); end
    testCount++; if (req_ready !== '0 || lane_in !== '0) begin failCount++; $display("FAIL idle_outputs: got ready %b lane %h, expected 0/0", req_ready, lane_in); end
    modelPtr  = 0;
    modelMism = 1'b0;
  endtask

  task automatic test_round_robin();
    obs_t o;
    int expId [5] = '{0, 1, 2, 3, 0};
    @(negedge clock);
    for (int i = 0; i < N; i++) set_word(i, W'(i + 1));
    for (int t = 0; t < 5; t++) begin
      txn('1, 0, o);
      testCount++; if (o.ok !== 1'b1) begin failCount++; $display("FAIL rr_accept[%0d]: got no accept, expected accept", t); end
      testCount++; if (o.respId !== IW'(expId[t])) begin failCount++; $display("FAIL rr_id[%0d]: got %0d, expected %0d", t, o.respId, expId[t]); end
      testCount++; if (o.respData !== W'(expId[t] + 1)) begin failCount++; $display("FAIL rr_data[%0d]: got %h, expected %h", t, o.respData, expId[t] + 1); end
      testCount++; if (o.rdy !== (N'(1) << expId[t])) begin failCount++; $display("FAIL rr_ready[%0d]: got %b, expected %b", t, o.rdy, N'(1) << expId[t]); end
      testCount++; if (o.midReady !== '0 || o.driveValid !== 1'b0) begin failCount++; $display("FAIL rr_busy_outputs[%0d]: got ready %b valid %b, expected 0/0", t, o.midReady, o.driveValid); end
      modelPtr = (expId[t] + 1) % N;
    end
  endtask

  task automatic test_single();
    obs_t o;
    @(negedge clock);
    for (int i = 0; i < N; i++) set_word(i, $urandom);
    set_word(2, 32'h0000_0003);
    txn(4'b0100, 0, o);
    testCount++; if (o.ok !== 1'b1 || o.respValid !== 1'b1) begin failCount++; $display("FAIL single_valid: got ok %b valid %b, expected 1/1", o.ok, o.respValid); end
    testCount++; if (o.lat !== 2) begin failCount++; $display("FAIL single_latency: got %0d, expected 2", o.lat); end
    testCount++; if (o.respId !== IW'(2)) begin failCount++; $display("FAIL single_id: got %0d, expected 2", o.respId); end
    testCount++; if (o.respData !== 32'h3) begin failCount++; $display("FAIL single_data: got %h, expected 00000003", o.respData); end
    testCount++; if (o.mism !== 1'b0) begin failCount++; $display("FAIL single_mismatch: got %b, expected 0", o.mism); end
    modelPtr = 3;
  endtask

  task automatic test_backpressure();
    obs_t o;
    int g;
    logic [W-1:0] expD;
    @(negedge clock);
    for (int i = 0; i < N; i++) set_word(i, $urandom);
    g    = model_pick('1);
    expD = model_lane(word_of(g), 1'b0);
    txn('1, 10, o);
    testCount++; if (o.lateValid !== 1'b1) begin failCount++; $display("FAIL bp_valid_held: got %b, expected 1", o.lateValid); end
    testCount++; if (o.lateData !== expD || o.respData !== expD) begin failCount++; $display("FAIL bp_data_stable: got %h then %h, expected %h", o.respData, o.lateData, expD); end
    testCount++; if (o.lateId !== IW'(g) || o.respId !== IW'(g)) begin failCount++; $display("FAIL bp_id_stable: got %0d then %0d, expected %0d", o.respId, o.lateId, g); end
    testCount++; if (o.midReady !== '0) begin failCount++; $display("FAIL bp_req_ready: got %b, expected 0", o.midReady); end
    testCount++; if (o.busyAfter !== 1'b0) begin failCount++; $display("FAIL bp_release_idle: got busy %b, expected 0", o.busyAfter); end
    modelPtr = (g + 1) % N;
  endtask

  task automatic test_fault();
    obs_t o;
    int g;
    logic [N-1:0] v;
    logic [W-1:0] expD;
    @(negedge clock);
    laneFault = 1'b1;
    set_word(0, 32'h0000_0001);
    txn(4'b0001, 0, o);
    testCount++; if (o.respData !== 32'h0) begin failCount++; $display("FAIL fault_data: got %h, expected 00000000", o.respData); end
    testCount++; if (o.mism !== 1'b1) begin failCount++; $display("FAIL fault_mismatch: got %b, expected 1", o.mism); end
    modelPtr  = 1;
    modelMism = 1'b1;
    laneFault = 1'b0;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < N; i++) set_word(i, $urandom);
      v    = N'($urandom_range(1, 15));
      g    = model_pick(v);
      expD = model_lane(word_of(g), 1'b0);
      txn(v, 0, o);
      testCount++; if (o.respData !== expD || o.respId !== IW'(g)) begin failCount++; $display("FAIL fault_good_txn[%0d]: got id %0d data %h, expected id %0d data %h", t, o.respId, o.respData, g, expD); end
      testCount++; if (o.mism !== 1'b1) begin failCount++; $display("FAIL fault_sticky[%0d]: got %b, expected 1", t, o.mism); end
      modelPtr = (g + 1) % N;
    end
  endtask

  task automatic test_reset_midop();
    obs_t o;
    logic seen;
    logic [W-1:0] d;
    @(negedge clock);
    set_word(1, $urandom | 32'h1);
    req_valid = 4'b0010;
    seen      = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      #1;
      if (req_ready !== '0) seen = 1'b1;
      else @(negedge clock);
    end
    testCount++; if (seen !== 1'b1) begin failCount++; $display("FAIL midop_accept: got no accept, expected accept"); end
    @(negedge clock);
    testCount++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin failCount++; $display("FAIL midop_drive: got busy %b valid %b, expected 1/0", busy, resp_valid); end
    reset = 1'b0;
    @(negedge clock);
    testCount++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin failCount++; $display("FAIL midop_abandon: got valid %b busy %b, expected 0/0", resp_valid, busy); end
    testCount++; if (lane_in !== '0 || resp_data !== '0) begin failCount++; $display("FAIL midop_clear: got lane %h data %h, expected 0/0", lane_in, resp_data); end
    testCount++; if (mismatch !== 1'b0 || req_ready !== '0) begin failCount++; $display("FAIL midop_flags: got mismatch %b ready %b, expected 0/0", mismatch, req_ready); end
    req_valid = '1;
    @(negedge clock);
    testCount++; if (resp_valid !== 1'b0) begin failCount++; $display("FAIL midop_no_resp: got %b, expected 0", resp_valid); end
    reset = 1'b1;
    #1;
    testCount++; if (req_ready !== 4'b0001) begin failCount++; $display("FAIL midop_ptr_zero: got %b, expected 0001", req_ready); end
    modelPtr  = 0;
    modelMism = 1'b0;
    d = $urandom;
    set_word(0, d);
    txn(4'b0001, 0, o);
    testCount++; if (o.respId !== '0 || o.respData !== d || o.mism !== 1'b0) begin failCount++; $display("FAIL midop_after: got id %0d data %h mm %b, expected 0 %h 0", o.respId, o.respData, o.mism, d); end
    modelPtr = 1;
  endtask

  task automatic test_sparse();
    obs_t o;
    logic [W-1:0] d;
    for (int t = 0; t < 3; t++) begin
      @(negedge clock);
      d = $urandom;
      set_word(3, d);
      txn(4'b1000, 0, o);
      testCount++; if (o.ok !== 1'b1 || o.respId !== IW'(3) || o.respData !== d) begin failCount++; $display("FAIL sparse_resp[%0d]: got ok %b id %0d data %h, expected 1 3 %h", t, o.ok, o.respId, o.respData, d); end
      // After serving requester 3 the pointer wraps, so requester 0 wins next.
      req_valid = '1;
      #1;
      testCount++; if (req_ready !== 4'b0001) begin failCount++; $display("FAIL sparse_wrap[%0d]: got %b, expected 0001", t, req_ready); end
      req_valid = '0;
      modelPtr = 0;
    end
  endtask

  task automatic test_random();
    obs_t o;
    int g;
    int gap;
    logic f;
    logic [N-1:0] v;
    logic [W-1:0] expD;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      gap = int'($urandom_range(0, 2));
      for (int c = 0; c < gap; c++) @(negedge clock);
      if (gap > 0) begin
        testCount++; if (busy !== 1'b0 || req_ready !== '0) begin failCount++; $display("FAIL rand_idle[%0d]: got busy %b ready %b, expected 0/0", t, busy, req_ready); end
      end
      for (int i = 0; i < N; i++) set_word(i, $urandom);
      v         = N'($urandom_range(1, 15));
      f         = ($urandom_range(0, 7) == 0);
      laneFault = f;
      g         = model_pick(v);
      expD      = model_lane(word_of(g), f);
      if (expD != word_of(g)) modelMism = 1'b1;
      txn(v, int'($urandom_range(0, 3)), o);
      laneFault = 1'b0;
      testCount++; if (o.ok !== 1'b1 || o.rdy !== (N'(1) << g)) begin failCount++; $display("FAIL rand_grant[%0d]: got ok %b ready %b, expected 1 %b", t, o.ok, o.rdy, N'(1) << g); end
      testCount++; if (o.respId !== IW'(g) || o.lateId !== IW'(g)) begin failCount++; $display("FAIL rand_id[%0d]: got %0d, expected %0d", t, o.respId, g); end
      testCount++; if (o.respData !== expD || o.lateData !== expD) begin failCount++; $display("FAIL rand_data[%0d]: got %h, expected %h", t, o.respData, expD); end
      testCount++; if (o.mism !== modelMism) begin failCount++; $display("FAIL rand_mismatch[%0d]: got %b, expected %b", t, o.mism, modelMism); end
      testCount++; if (o.lat !== 2 || o.respValid !== 1'b1) begin failCount++; $display("FAIL rand_latency[%0d]: got %0d valid %b, expected 2 1", t, o.lat, o.respValid); end
      testCount++; if (o.midReady !== '0 || o.busyAfter !== 1'b0) begin failCount++; $display("FAIL rand_handshake[%0d]: got ready %b busy %b, expected 0/0", t, o.midReady, o.busyAfter); end
      modelPtr = (g + 1) % N;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_fault();
    test_reset_midop();
    test_sparse();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000ns, expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
